// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - op codes, FSM state type and decode helpers for the load/store unit
package lsu_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  // loads occupy the low five op codes
  function automatic logic is_load(input logic [2:0] op);
    return op <= OP_LHU;
  endfunction

  // anything narrower than a full word
  function automatic logic is_sub(input logic [2:0] op);
    return (op != OP_LW) && (op != OP_SW);
  endfunction

  function automatic logic [1:0] access_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// rtl/lsu_lane_mux.sv - little-endian lane extraction/extension for loads and lane merge for sub-word stores
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // pick the addressed lane, extend it for loads, and splice it in for stores
  always_comb begin
    lane_b     = word[{byte_off, 3'b000} +: 8];
    lane_h     = byte_off[1] ? word[31:16] : word[15:0];
    load_data  = word;
    store_word = word;
    case (op)
      OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      OP_LBU:  load_data = {24'h0, lane_b};
      OP_LHU:  load_data = {16'h0, lane_h};
      default: load_data = word;
    endcase
    case (op)
      OP_SB: store_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
      OP_SH: begin
        if (byte_off[1]) store_word[31:16] = store_data[15:0];
        else             store_word[15:0]  = store_data[15:0];
      end
      OP_SW:   store_word = store_data;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed load/store front end for a word memory; LSU_SUBWORD_EN enables byte/halfword ops
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] ByteAddr,
  input  logic [31:0] StoreData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] LoadData,
  output logic        Error,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  state_t      state;
  logic        misalign;
  logic        out_of_range;
  logic        unsupported;
  logic        req_err;
  logic [31:0] word_idx;

`ifdef LSU_SUBWORD_EN
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] store_q;
  logic [31:0] lane_load;
  logic [31:0] lane_store;

  lsu_lane_mux u_lane_mux (
    .op         (op_q),
    .byte_off   (off_q),
    .word       (MemReadData),
    .store_data (store_q),
    .load_data  (lane_load),
    .store_word (lane_store)
  );
`endif

  // classify the incoming request before it is accepted
  always_comb begin
    misalign     = ((access_size(Op) == SZ_HALF) && ByteAddr[0]) ||
                   ((access_size(Op) == SZ_WORD) && (ByteAddr[1:0] != 2'b00));
    out_of_range = |(ByteAddr >> (IDX_W + 2));
`ifdef LSU_SUBWORD_EN
    unsupported  = 1'b0;
`else
    unsupported  = is_sub(Op);
`endif
    req_err      = misalign || out_of_range || unsupported;
    word_idx     = {{(32 - IDX_W){1'b0}}, ByteAddr[IDX_W+1:2]};
  end

  // request sequencer; every memory-facing output is a flop so it only moves on an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
      LoadData     <= 32'h0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      MemAddress   <= 32'h0;
      MemWriteData <= 32'h0;
`ifdef LSU_SUBWORD_EN
      op_q         <= 3'd0;
      off_q        <= 2'd0;
      store_q      <= 32'h0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            Busy  <= 1'b1;
            Error <= 1'b0;
`ifdef LSU_SUBWORD_EN
            op_q    <= Op;
            off_q   <= ByteAddr[1:0];
            store_q <= StoreData;
`endif
            if (req_err) begin
              state <= DONE;
              Done  <= 1'b1;
              Error <= 1'b1;
            end else if (Op == OP_SW) begin
              state        <= WRITE;
              MemWrite     <= 1'b1;
              MemAddress   <= word_idx;
              MemWriteData <= StoreData;
            end else begin
              state      <= READ;
              MemRead    <= 1'b1;
              MemAddress <= word_idx;
            end
          end
        end
        READ: begin
          MemRead <= 1'b0;
`ifdef LSU_SUBWORD_EN
          if (is_load(op_q)) begin
            LoadData <= lane_load;
            state    <= DONE;
            Done     <= 1'b1;
          end else begin
            MemWriteData <= lane_store;
            MemWrite     <= 1'b1;
            state        <= WRITE;
          end
`else
          LoadData <= MemReadData;
          state    <= DONE;
          Done     <= 1'b1;
`endif
        end
        WRITE: begin
          MemWrite <= 1'b0;
          state    <= DONE;
          Done     <= 1'b1;
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a behavioural word memory
module tb_load_store_unit;

`ifdef LSU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] ByteAddr = 32'h0;
  logic [31:0] StoreData = 32'h0;
  logic        Busy, Done, Error, MemRead, MemWrite;
  logic [31:0] LoadData, MemAddress, MemWriteData, MemReadData;

  logic [31:0] mem [256];
  int          errs = 0;
  int          checks = 0;
  int          both_cnt = 0;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .Start        (Start),
    .Op           (Op),
    .ByteAddr     (ByteAddr),
    .StoreData    (StoreData),
    .Busy         (Busy),
    .Done         (Done),
    .LoadData     (LoadData),
    .Error        (Error),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemReadData  (MemReadData)
  );

  always #5 clk = ~clk;

  assign MemReadData = mem[MemAddress[7:0]];

  always @(posedge clk) begin
    if (MemWrite) mem[MemAddress[7:0]] = MemWriteData;
  end

  always @(negedge clk) begin
    if (MemRead && MemWrite) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // issue one request from IDLE and measure edges from acceptance to Done plus strobe cycles
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        output int lat, output int rd, output int wr, output logic [31:0] waddr);
    int guard;
    guard = 0;
    while (Busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    Start = 1'b1; Op = op; ByteAddr = addr; StoreData = data;
    @(posedge clk);
    #1 Start = 1'b0;
    lat = 1; rd = 0; wr = 0; waddr = 32'hFFFFFFFF;
    @(negedge clk);
    while (!Done && lat < 8) begin
      rd += int'(MemRead);
      wr += int'(MemWrite);
      if (MemWrite) waddr = MemAddress;
      @(negedge clk);
      lat++;
    end
    if (!Done) lat = 99;
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                     input int e_lat, input logic e_err, input logic [31:0] e_load, input int e_rd, input int e_wr);
    int lat, rd, wr;
    logic [31:0] wa;
    do_req(op, addr, data, lat, rd, wr, wa);
    check({tag, ".lat"}, lat, e_lat);
    check({tag, ".err"}, {31'h0, Error}, {31'h0, e_err});
    check({tag, ".load"}, LoadData, e_load);
    check({tag, ".rd"}, rd, e_rd);
    check({tag, ".wr"}, wr, e_wr);
  endtask

  initial begin
    int lat, rd, wr, dcnt;
    logic [31:0] wa, last;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8] = 32'h8081F07F;

    // reset state
    repeat (2) @(negedge clk);
    check("rst.busy", {31'h0, Busy}, 32'h0);
    check("rst.done", {31'h0, Done}, 32'h0);
    check("rst.err", {31'h0, Error}, 32'h0);
    check("rst.load", LoadData, 32'h0);
    check("rst.strobes", {30'h0, MemRead, MemWrite}, 32'h0);
    check("rst.addr", MemAddress, 32'h0);
    check("rst.wdata", MemWriteData, 32'h0);
    #2 reset = 1'b0;
    @(negedge clk);

    // full-word store then load
    do_req(OP_SW_C(), 32'h10, 32'hDEADBEEF, lat, rd, wr, wa);
    check("sw.lat", lat, 2);
    check("sw.wr", wr, 1);
    check("sw.rd", rd, 0);
    check("sw.addr", wa, 32'd4);
    check("sw.err", {31'h0, Error}, 32'h0);
    check("sw.mem", mem[4], 32'hDEADBEEF);
    run("lw10", 3'd2, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF, 1, 0);

    // byte store into lane 1
    last = 32'hDEADBEEF;
    if (SUB) run("sb11", 3'd5, 32'h11, 32'h000000AA, 3, 1'b0, last, 1, 1);
    else     run("sb11", 3'd5, 32'h11, 32'h000000AA, 1, 1'b1, last, 0, 0);
    check("sb.mem", mem[4], SUB ? 32'hDEADAAEF : 32'hDEADBEEF);
    last = SUB ? 32'hDEADAAEF : 32'hDEADBEEF;
    run("lw10b", 3'd2, 32'h10, 32'h0, 2, 1'b0, last, 1, 0);

    // sub-word loads from 0x8081F07F
    if (SUB) begin
      run("lb20", 3'd0, 32'h20, 32'h0, 2, 1'b0, 32'h0000007F, 1, 0);
      run("lb21", 3'd0, 32'h21, 32'h0, 2, 1'b0, 32'hFFFFFFF0, 1, 0);
      run("lbu21", 3'd3, 32'h21, 32'h0, 2, 1'b0, 32'h000000F0, 1, 0);
      run("lh22", 3'd1, 32'h22, 32'h0, 2, 1'b0, 32'hFFFF8081, 1, 0);
      run("lhu22", 3'd4, 32'h22, 32'h0, 2, 1'b0, 32'h00008081, 1, 0);
      last = 32'h00008081;
    end else begin
      run("lb20", 3'd0, 32'h20, 32'h0, 1, 1'b1, last, 0, 0);
      run("lhu22", 3'd4, 32'h22, 32'h0, 1, 1'b1, last, 0, 0);
    end

    // misaligned and out-of-range requests
    run("lw22", 3'd2, 32'h22, 32'h0, 1, 1'b1, last, 0, 0);
    run("lw400", 3'd2, 32'h400, 32'h0, 1, 1'b1, last, 0, 0);
    run("sw402", 3'd7, 32'h402, 32'h12345678, 1, 1'b1, last, 0, 0);
    run("lw20", 3'd2, 32'h20, 32'h0, 2, 1'b0, 32'h8081F07F, 1, 0);

    // Start held high through a busy request
    @(negedge clk);
    Start = 1'b1; Op = 3'd2; ByteAddr = 32'h20;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) Start = 1'b0;
      dcnt += int'(Done);
    end
    check("busy.dones", dcnt, 1);

    // reset asserted during the WRITE cycle
    @(negedge clk);
    Start = 1'b1;
    Op = SUB ? 3'd6 : 3'd7;
    ByteAddr = SUB ? 32'h12 : 32'h10;
    StoreData = 32'h11112222;
    @(posedge clk);
    #1 Start = 1'b0;
    @(negedge clk);
    if (SUB) @(negedge clk);
    check("rstw.wr_before", {31'h0, MemWrite}, 32'h1);
    #1 reset = 1'b1;
    #1;
    check("rstw.wr_after", {31'h0, MemWrite}, 32'h0);
    check("rstw.busy", {30'h0, Busy, Done}, 32'h0);
    check("rstw.load", LoadData, 32'h0);
    check("rstw.addr", MemAddress, 32'h0);
    @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    check("rstw.mem", mem[4], SUB ? 32'hDEADAAEF : 32'hDEADBEEF);
    run("post_rst", 3'd2, 32'h10, 32'h0, 2, 1'b0, SUB ? 32'hDEADAAEF : 32'hDEADBEEF, 1, 0);

    check("rw_exclusive", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  function automatic logic [2:0] OP_SW_C();
    return 3'd7;
  endfunction

endmodule
